// File: rtl/interp_plane_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_plane_seq
// Purpose  : Walks a triangle's pixel bounding box in raster order. For every
//            pixel it drives each parameter plane in turn to a shared
//            multi-cycle interpolator, collects one result per plane and then
//            emits the pixel with all plane results on a valid/ready port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset          : sole clock, asynchronous active-high reset
//   abort                 : synchronous flush of the triangle in flight
//   tri_valid/tri_ready   : triangle handshake
//   tri_planes            : planes to evaluate (0 -> 1, clamped to NPLANE)
//   tri_fx, tri_fy        : three signed 32b vertex X/Y, vertex 1 in [31:0]
//   tri_fz                : per-plane vertex Z triples, plane p at [p*96 +: 96]
//   tri_x0/x1, tri_y0/y1  : inclusive pixel bounding box
//   ip_fx, ip_fy, ip_fz   : vertex data presented to the shared interpolator
//   ip_x, ip_y            : pixel coordinate << FRAC_BITS
//   ip_interp             : interpolator result (signed 64b)
//   px_valid/px_ready     : pixel handshake
//   px_x, px_y, px_val    : pixel coordinate and per-plane results
//   px_last               : last pixel of the triangle
//   tri_done              : one-cycle pulse when a triangle completes
// ============================================================================
module interp_plane_seq #(
  parameter int NPLANE    = 4,
  parameter int SETUP_LAT = 2,
  parameter int FRAC_BITS = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  abort,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [2:0]            tri_planes,
  input  logic [95:0]           tri_fx,
  input  logic [95:0]           tri_fy,
  input  logic [NPLANE*96-1:0]  tri_fz,
  input  logic [11:0]           tri_x0,
  input  logic [11:0]           tri_x1,
  input  logic [11:0]           tri_y0,
  input  logic [11:0]           tri_y1,
  output logic [95:0]           ip_fx,
  output logic [95:0]           ip_fy,
  output logic [95:0]           ip_fz,
  output logic [31:0]           ip_x,
  output logic [31:0]           ip_y,
  input  logic [63:0]           ip_interp,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [11:0]           px_x,
  output logic [11:0]           px_y,
  output logic [NPLANE*64-1:0]  px_val,
  output logic                  px_last,
  output logic                  tri_done
);

  localparam int WW = (SETUP_LAT > 0) ? $clog2(SETUP_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [95:0]           r_fx;
  logic [95:0]           r_fy;
  logic [NPLANE*96-1:0]  r_fz;
  logic [NPLANE*64-1:0]  r_res;
  logic [11:0]           r_x0, r_x1, r_y0, r_y1;
  logic [11:0]           r_x, r_y;
  logic [2:0]            r_planes;
  logic [2:0]            r_p;
  logic [WW-1:0]         r_w;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_degen;
  logic                  w_plane_end;
  logic                  w_last_plane;
  logic                  w_at_x1;
  logic                  w_pix_last;
  logic                  w_hs;
  logic [2:0]            w_planes;

  assign tri_ready    = (r_state == S_IDLE) && !abort;
  assign w_accept     = tri_valid && tri_ready;
  assign w_degen      = (tri_x0 > tri_x1) || (tri_y0 > tri_y1);
  assign w_plane_end  = (r_w == WW'(SETUP_LAT));
  assign w_last_plane = (r_p == (r_planes - 3'd1));
  assign w_at_x1      = (r_x == r_x1);
  assign w_pix_last   = w_at_x1 && (r_y == r_y1);
  // abort wins over px_ready: a simultaneous ready is not a transfer
  assign w_hs         = (r_state == S_EMIT) && px_ready && !abort;

  // zero planes means one; anything above the slot count is clamped
  assign w_planes = (tri_planes == 3'd0) ? 3'd1 :
                    ((32'(tri_planes) > NPLANE) ? 3'(NPLANE) : tri_planes);

  // Interpolator side: everything comes from latched state, so it only moves
  // when p or the pixel counters advance.
  assign ip_fx = r_fx;
  assign ip_fy = r_fy;
  assign ip_x  = 32'(r_x) << FRAC_BITS;
  assign ip_y  = 32'(r_y) << FRAC_BITS;

  always_comb begin
    ip_fz = '0;
    for (int i = 0; i < NPLANE; i++) begin
      if (r_p == 3'(i)) ip_fz = r_fz[i*96 +: 96];
    end
  end

  assign px_valid = (r_state == S_EMIT);
  assign px_last  = px_valid && w_pix_last;
  assign px_x     = r_x;
  assign px_y     = r_y;
  assign tri_done = r_done;

  // Slots beyond the active plane count may hold results of an earlier
  // triangle, so they are masked rather than cleared.
  for (genvar g = 0; g < NPLANE; g++) begin : g_slot
    assign px_val[g*64 +: 64] = (3'(g) < r_planes) ? r_res[g*64 +: 64] : 64'd0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_degen) w_next = S_DRIVE;
      S_DRIVE: begin
        if (abort)                            w_next = S_IDLE;
        else if (w_plane_end && w_last_plane) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (abort)     w_next = S_IDLE;
        else if (w_hs) w_next = w_pix_last ? S_IDLE : S_DRIVE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fx     <= '0;
      r_fy     <= '0;
      r_fz     <= '0;
      r_res    <= '0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_y0     <= '0;
      r_y1     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_planes <= '0;
      r_p      <= '0;
      r_w      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_accept && w_degen) || (w_hs && w_pix_last);
      if (w_accept) begin
        r_fx     <= tri_fx;
        r_fy     <= tri_fy;
        r_fz     <= tri_fz;
        r_x0     <= tri_x0;
        r_x1     <= tri_x1;
        r_y0     <= tri_y0;
        r_y1     <= tri_y1;
        r_x      <= tri_x0;
        r_y      <= tri_y0;
        r_planes <= w_planes;
        r_p      <= '0;
        r_w      <= '0;
      end else if (r_state == S_DRIVE && !abort) begin
        if (w_plane_end) begin
          for (int i = 0; i < NPLANE; i++) begin
            if (r_p == 3'(i)) r_res[i*64 +: 64] <= ip_interp;
          end
          r_w <= '0;
          // p returns to 0 after the last plane so ip_fz stays in range
          r_p <= w_last_plane ? 3'd0 : r_p + 3'd1;
        end else begin
          r_w <= r_w + WW'(1);
        end
      end else if (w_hs) begin
        if (w_at_x1) begin
          r_x <= r_x0;
          r_y <= r_y + 12'd1;
        end else begin
          r_x <= r_x + 12'd1;
        end
        r_p <= '0;
        r_w <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interp_plane_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_interp_plane_seq
// Purpose  : Directed self-checking bench for interp_plane_seq. A behavioural
//            interpolator returns {z1_p + ip_y + bump, ip_x} so each stored
//            result identifies the plane and pixel it was sampled for.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_plane_seq;

  localparam int NPLANE    = 4;
  localparam int SETUP_LAT = 2;
  localparam int FRAC_BITS = 12;
  localparam logic [95:0] FX = 96'h0000_0030_0000_0020_0000_0010;
  localparam logic [95:0] FY = 96'h0000_0060_0000_0050_0000_0040;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  abort = 1'b0;
  logic                  tri_valid = 1'b0;
  logic                  tri_ready;
  logic [2:0]            tri_planes = 3'd0;
  logic [95:0]           tri_fx = FX;
  logic [95:0]           tri_fy = FY;
  logic [NPLANE*96-1:0]  tri_fz;
  logic [11:0]           tri_x0 = 12'd0, tri_x1 = 12'd0, tri_y0 = 12'd0, tri_y1 = 12'd0;
  logic [95:0]           ip_fx, ip_fy, ip_fz;
  logic [31:0]           ip_x, ip_y;
  logic [63:0]           ip_interp;
  logic                  px_valid;
  logic                  px_ready = 1'b0;
  logic [11:0]           px_x, px_y;
  logic [NPLANE*64-1:0]  px_val;
  logic                  px_last;
  logic                  tri_done;
  logic [31:0]           bump = 32'd0;

  int checks   = 0;
  int failures = 0;

  interp_plane_seq #(.NPLANE(NPLANE), .SETUP_LAT(SETUP_LAT), .FRAC_BITS(FRAC_BITS)) dut (
    .clock(clock), .reset(reset), .abort(abort),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_planes(tri_planes),
    .tri_fx(tri_fx), .tri_fy(tri_fy), .tri_fz(tri_fz),
    .tri_x0(tri_x0), .tri_x1(tri_x1), .tri_y0(tri_y0), .tri_y1(tri_y1),
    .ip_fx(ip_fx), .ip_fy(ip_fy), .ip_fz(ip_fz), .ip_x(ip_x), .ip_y(ip_y),
    .ip_interp(ip_interp),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .px_val(px_val), .px_last(px_last), .tri_done(tri_done)
  );

  always #5 clock = ~clock;

  assign ip_interp = {ip_fz[31:0] + ip_y + bump, ip_x};

  function automatic logic [31:0] zv(input int p);
    return 32'h100 * 32'(p + 1) + 32'd7;
  endfunction

  function automatic logic [95:0] fz_slot(input int p);
    return {32'hC0 + 32'(p), 32'hB0 + 32'(p), zv(p)};
  endfunction

  function automatic logic [63:0] exp_val(input int p, input int x, input int y);
    return {zv(p) + (32'(y) << FRAC_BITS), 32'(x) << FRAC_BITS};
  endfunction

  function automatic logic [63:0] slot(input logic [NPLANE*64-1:0] v, input int p);
    return v[p*64 +: 64];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Presents a triangle for exactly one edge; returns one cycle after acceptance.
  task automatic drive_tri(input logic [11:0] x0, input logic [11:0] x1,
                           input logic [11:0] y0, input logic [11:0] y1,
                           input logic [2:0] pl);
    tri_x0 = x0; tri_x1 = x1; tri_y0 = y0; tri_y1 = y1; tri_planes = pl;
    tri_valid = 1'b1;
    cyc();
    tri_valid = 1'b0;
  endtask

  task automatic wait_valid(inout int t);
    while (px_valid !== 1'b1 && t < 200) begin
      cyc();
      t++;
    end
  endtask

  task automatic test_reset();
    checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL reset_tri_ready: got %b want 1", tri_ready); end
    checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
    checks++; if (px_last !== 1'b0 || tri_done !== 1'b0) begin failures++; $display("FAIL reset_last_done: got %b%b want 00", px_last, tri_done); end
    checks++; if (px_x !== 12'd0 || px_y !== 12'd0) begin failures++; $display("FAIL reset_px_xy: got %h,%h want 0,0", px_x, px_y); end
    checks++; if (px_val !== '0) begin failures++; $display("FAIL reset_px_val: got %h want 0", px_val); end
    checks++; if (ip_x !== 32'd0 || ip_fz !== 96'd0 || ip_fx !== 96'd0) begin failures++; $display("FAIL reset_ip: got x=%h fz=%h fx=%h want 0", ip_x, ip_fz, ip_fx); end
  endtask

  task automatic test_single_pixel();
    checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", tri_ready); end
    drive_tri(12'd5, 12'd5, 12'd5, 12'd5, 3'd1);
    checks++; if (ip_x !== 32'h5000 || ip_y !== 32'h5000) begin failures++; $display("FAIL single_ip_xy: got %h,%h want 5000,5000", ip_x, ip_y); end
    checks++; if (ip_fx !== FX || ip_fy !== FY) begin failures++; $display("FAIL single_ip_fxfy: got %h,%h want %h,%h", ip_fx, ip_fy, FX, FY); end
    checks++; if (ip_fz !== fz_slot(0)) begin failures++; $display("FAIL single_ip_fz: got %h want %h", ip_fz, fz_slot(0)); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: T+%0d got %b want 0", i, px_valid); end
      cyc();
    end
    checks++; if (px_valid !== 1'b1) begin failures++; $display("FAIL single_valid_T4: got %b want 1", px_valid); end
    checks++; if (px_x !== 12'd5 || px_y !== 12'd5 || px_last !== 1'b1) begin failures++; $display("FAIL single_px: got %0d,%0d last=%b want 5,5 last=1", px_x, px_y, px_last); end
    checks++; if (slot(px_val, 0) !== exp_val(0, 5, 5)) begin failures++; $display("FAIL single_val0: got %h want %h", slot(px_val, 0), exp_val(0, 5, 5)); end
    checks++; if (slot(px_val, 1) !== 64'd0) begin failures++; $display("FAIL single_val1: got %h want 0", slot(px_val, 1)); end
    px_ready = 1'b1;
    cyc();
    px_ready = 1'b0;
    checks++; if (tri_done !== 1'b1 || tri_ready !== 1'b1 || px_valid !== 1'b0) begin failures++; $display("FAIL single_done: got done=%b ready=%b valid=%b want 1,1,0", tri_done, tri_ready, px_valid); end
    cyc();
    checks++; if (tri_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", tri_done); end
  endtask

  task automatic test_raster();
    int t;
    px_ready = 1'b1;
    drive_tri(12'd0, 12'd1, 12'd0, 12'd1, 3'd2);
    t = 1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(t);
      checks++; if (t !== 7 + 7 * k) begin failures++; $display("FAIL raster_time%0d: got %0d want %0d", k, t, 7 + 7 * k); end
      checks++; if (px_x !== 12'(k % 2) || px_y !== 12'(k / 2)) begin failures++; $display("FAIL raster_xy%0d: got %0d,%0d want %0d,%0d", k, px_x, px_y, k % 2, k / 2); end
      checks++; if (px_last !== (k == 3)) begin failures++; $display("FAIL raster_last%0d: got %b want %b", k, px_last, k == 3); end
      for (int p = 0; p < 2; p++) begin
        checks++; if (slot(px_val, p) !== exp_val(p, k % 2, k / 2)) begin failures++; $display("FAIL raster_val%0d_%0d: got %h want %h", k, p, slot(px_val, p), exp_val(p, k % 2, k / 2)); end
      end
      checks++; if (slot(px_val, 2) !== 64'd0 || slot(px_val, 3) !== 64'd0) begin failures++; $display("FAIL raster_zero%0d: got %h,%h want 0,0", k, slot(px_val, 2), slot(px_val, 3)); end
      cyc();
      t++;
    end
    px_ready = 1'b0;
    checks++; if (tri_done !== 1'b1) begin failures++; $display("FAIL raster_done: got %b want 1", tri_done); end
    cyc();
  endtask

  task automatic test_backpressure();
    int t;
    px_ready = 1'b0;
    drive_tri(12'd2, 12'd3, 12'd1, 12'd1, 3'd3);
    t = 1;
    wait_valid(t);
    checks++; if (t !== 10) begin failures++; $display("FAIL bp_time: got %0d want 10", t); end
    bump = 32'h55;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (px_valid !== 1'b1 || px_x !== 12'd2 || px_y !== 12'd1 || px_last !== 1'b0 ||
          slot(px_val, 0) !== exp_val(0, 2, 1) || slot(px_val, 2) !== exp_val(2, 2, 1) || ip_x !== 32'h2000) begin
        failures++;
        $display("FAIL bp_stall%0d: got v=%b xy=%0d,%0d last=%b s0=%h s2=%h ipx=%h want 1,2,1,0,%h,%h,2000",
                 i, px_valid, px_x, px_y, px_last, slot(px_val, 0), slot(px_val, 2), ip_x, exp_val(0, 2, 1), exp_val(2, 2, 1));
      end
      cyc();
    end
    bump = 32'd0;
    px_ready = 1'b1;
    cyc();
    px_ready = 1'b0;
    checks++; if (px_valid !== 1'b0 || px_x !== 12'd3 || ip_x !== 32'h3000) begin failures++; $display("FAIL bp_advance: got v=%b x=%0d ipx=%h want 0,3,3000", px_valid, px_x, ip_x); end
    t = 1;
    wait_valid(t);
    checks++; if (t !== 10 || px_last !== 1'b1) begin failures++; $display("FAIL bp_second: got t=%0d last=%b want 10,1", t, px_last); end
    checks++; if (slot(px_val, 1) !== exp_val(1, 3, 1)) begin failures++; $display("FAIL bp_val: got %h want %h", slot(px_val, 1), exp_val(1, 3, 1)); end
    px_ready = 1'b1;
    cyc();
    px_ready = 1'b0;
    cyc();
  endtask

  task automatic test_degenerate_clamp();
    int t;
    drive_tri(12'd3, 12'd2, 12'd0, 12'd0, 3'd1);
    checks++; if (tri_done !== 1'b1 || px_valid !== 1'b0 || tri_ready !== 1'b1) begin failures++; $display("FAIL degen_done: got done=%b valid=%b ready=%b want 1,0,1", tri_done, px_valid, tri_ready); end
    repeat (6) cyc();
    checks++; if (tri_done !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL degen_quiet: got done=%b valid=%b want 0,0", tri_done, px_valid); end
    drive_tri(12'd4, 12'd4, 12'd2, 12'd2, 3'd7);
    t = 1;
    wait_valid(t);
    checks++; if (t !== 13) begin failures++; $display("FAIL clamp7_time: got %0d want 13", t); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (slot(px_val, p) !== exp_val(p, 4, 2)) begin failures++; $display("FAIL clamp7_val%0d: got %h want %h", p, slot(px_val, p), exp_val(p, 4, 2)); end
    end
    px_ready = 1'b1; cyc(); px_ready = 1'b0; cyc();
    drive_tri(12'd1, 12'd1, 12'd1, 12'd1, 3'd0);
    t = 1;
    wait_valid(t);
    checks++; if (t !== 4) begin failures++; $display("FAIL clamp0_time: got %0d want 4", t); end
    checks++; if (slot(px_val, 0) !== exp_val(0, 1, 1) || slot(px_val, 1) !== 64'd0) begin failures++; $display("FAIL clamp0_val: got %h,%h want %h,0", slot(px_val, 0), slot(px_val, 1), exp_val(0, 1, 1)); end
    px_ready = 1'b1; cyc(); px_ready = 1'b0; cyc();
  endtask

  task automatic test_abort();
    int t;
    drive_tri(12'd0, 12'd1, 12'd0, 12'd0, 3'd2);
    cyc();
    abort = 1'b1;
    #1;
    checks++; if (tri_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_drive: got %b want 0", tri_ready); end
    cyc();
    abort = 1'b0;
    #1;
    checks++; if (px_valid !== 1'b0 || tri_ready !== 1'b1 || tri_done !== 1'b0) begin failures++; $display("FAIL abort_idle: got valid=%b ready=%b done=%b want 0,1,0", px_valid, tri_ready, tri_done); end
    repeat (8) cyc();
    checks++; if (px_valid !== 1'b0 || tri_done !== 1'b0) begin failures++; $display("FAIL abort_stays: got valid=%b done=%b want 0,0", px_valid, tri_done); end
    // abort in IDLE only blocks acceptance for that one cycle
    tri_x0 = 12'd7; tri_x1 = 12'd7; tri_y0 = 12'd7; tri_y1 = 12'd7; tri_planes = 3'd1;
    abort = 1'b1;
    tri_valid = 1'b1;
    #1;
    checks++; if (tri_ready !== 1'b0) begin failures++; $display("FAIL abort_idle_block: got %b want 0", tri_ready); end
    cyc();
    abort = 1'b0;
    #1;
    checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_notaken: got ready=%b want 1", tri_ready); end
    cyc();
    tri_valid = 1'b0;
    t = 1;
    wait_valid(t);
    checks++; if (t !== 4 || px_x !== 12'd7) begin failures++; $display("FAIL abort_new_tri: got t=%0d x=%0d want 4,7", t, px_x); end
    abort = 1'b1;
    px_ready = 1'b1;
    cyc();
    abort = 1'b0;
    px_ready = 1'b0;
    checks++; if (tri_done !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL abort_emit: got done=%b valid=%b want 0,0", tri_done, px_valid); end
    cyc();
    checks++; if (tri_done !== 1'b0) begin failures++; $display("FAIL abort_emit_late: got done=%b want 0", tri_done); end
  endtask

  task automatic test_reset_mid_emit();
    int t;
    drive_tri(12'd9, 12'd9, 12'd9, 12'd9, 3'd1);
    t = 1;
    wait_valid(t);
    checks++; if (px_valid !== 1'b1) begin failures++; $display("FAIL rst_pre: got %b want 1", px_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (px_valid !== 1'b0 || tri_ready !== 1'b1 || px_x !== 12'd0) begin failures++; $display("FAIL rst_async: got valid=%b ready=%b x=%0d want 0,1,0", px_valid, tri_ready, px_x); end
    #1 reset = 1'b0;
    cyc();
    checks++; if (tri_done !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL rst_nodone: got done=%b valid=%b want 0,0", tri_done, px_valid); end
  endtask

  initial begin
    for (int p = 0; p < NPLANE; p++) tri_fz[p*96 +: 96] = fz_slot(p);
    #2;
    test_reset();
    @(posedge clock);
    @(posedge clock);
    #4 reset = 1'b0;
    cyc();
    test_single_pixel();
    test_raster();
    test_backpressure();
    test_degenerate_clamp();
    test_abort();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interp_plane_seq.md
INTERP_PLANE_SEQ -- requirements
Module: interp_plane_seq

Interface
REQ-001 The block SHALL have parameters: NPLANE, default 4, max parameter planes per triangle; SETUP_LAT, default 2, settle cycles of the shared interpolator; FRAC_BITS, default 12, fixed-point fraction bits of the pixel coordinates.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have the following ports, as name, direction, width, meaning:
- clock  in  1  sole clock.
- reset  in  1  async active-high reset.
- abort  in  1  sync flush of the current triangle.
- tri_valid  in  1  triangle offered.
- tri_ready  out  1  triangle accepted when high with tri_valid.
- tri_planes  in  3  planes to evaluate.
- tri_fx, tri_fy  in  96 each  three signed 32b vertex X/Y, vertex 1 in bits [31:0].
- tri_fz  in  NPLANE*96  per-plane three signed 32b Z values, plane p at bits [p*96 +: 96].
- tri_x0, tri_x1, tri_y0, tri_y1  in  12 each  inclusive pixel bounding box.
- ip_fx, ip_fy, ip_fz  out  96 each  vertex data to the shared interpolator.
- ip_x, ip_y  out  32 each  signed pixel coordinate << FRAC_BITS.
- ip_interp  in  64  signed interpolator result.
- px_valid  out  1  pixel result valid.
- px_ready  in  1  pixel consumer ready.
- px_x, px_y  out  12 each  pixel coordinate.
- px_val  out  NPLANE*64  per-plane results, plane p at bits [p*64 +: 64].
- px_last  out  1  last pixel of the triangle.
- tri_done  out  1  one-cycle pulse at triangle end.

Function
REQ-004 The FSM SHALL have states IDLE, DRIVE and EMIT; tri_ready SHALL equal (state==IDLE) && !abort.
REQ-005 On acceptance, the block SHALL latch all tri_* inputs.
- Plane count: 0 becomes 1; values above NPLANE clamp to NPLANE.
- Pixel counters x=tri_x0, y=tri_y0; plane index p=0; wait counter w=0.
REQ-006 If tri_x0>tri_x1 or tri_y0>tri_y1 at acceptance, the block SHALL return to IDLE, pulse tri_done in the next cycle and emit no pixels.
- Otherwise the next state SHALL be DRIVE.
REQ-007 The ip_* outputs SHALL be driven from latched data.
- ip_fx and ip_fy hold the latched vertices.
- ip_fz is the slot of plane p.
- ip_x = zero-extended x << FRAC_BITS; ip_y likewise.
- ip_* SHALL be stable throughout each plane's DRIVE window.
REQ-008 DRIVE SHALL count w from 0 to SETUP_LAT, so each plane takes SETUP_LAT+1 cycles.
- In the cycle with w==SETUP_LAT, ip_interp is stored into result slot p.
- w then clears and p increments.
- After the last plane, the state SHALL go to EMIT.
REQ-009 In EMIT, px_valid SHALL be high and px_x, px_y, px_val and px_last SHALL be held stable until px_ready.
- Slots at or above the plane count SHALL read zero.
REQ-010 On the EMIT handshake the block SHALL advance in raster order, x fastest.
- x reaching tri_x1 wraps to tri_x0 and y increments.
- The next state is DRIVE with p=0, w=0.
REQ-011 px_last SHALL be high only when x==tri_x1 and y==tri_y1.
- Its handshake SHALL return to IDLE and pulse tri_done in the following cycle; tri_ready is high in that same cycle.
REQ-012 abort SHALL take priority in DRIVE and EMIT.
- Next state IDLE; px_valid low next cycle; no tri_done.
- A px_ready in the abort cycle SHALL NOT count as a handshake.
- abort in IDLE SHALL block acceptance in that cycle only.
REQ-013 Latency from acceptance (cycle T) to the first px_valid SHALL be T+1+planes*(SETUP_LAT+1).
REQ-014 Sustained throughput with px_ready held high SHALL be one pixel per planes*(SETUP_LAT+1)+1 cycles.

Reset
REQ-015 The following SHALL hold while reset is high, with immediate asynchronous effect:
- State IDLE, tri_ready=1.
- px_valid=0, px_last=0, tri_done=0.
- px_x=px_y=0, px_val=0, ip_*=0, and all counters and latches zero.
- Reset mid-triangle discards the triangle without tri_done.

Verification
REQ-016 The bench SHALL cover the following directed scenarios:
- Single pixel: box (5,5)-(5,5), planes=1, SETUP_LAT=2, accept at T → px_valid at T+4 with px_x=5, px_y=5, px_last=1, ip_x=0x5000; tri_done at handshake+1.
- Raster: box (0,0)-(1,1), planes=2, px_ready=1 → pixel order (0,0),(1,0),(0,1),(1,1), 7 cycles apart; px_last only on (1,1); slots 2-3 zero.
- Backpressure: px_ready low 10 cycles in EMIT → px_* stable, no counter advance, no extra ip sampling.
- Degenerate/clamp: tri_x0=3, tri_x1=2 → tri_done at T+1, no px_valid; tri_planes=7 → 4 planes evaluated; tri_planes=0 → 1 plane.
- Abort/reset: abort in DRIVE → IDLE next cycle, no tri_done, new triangle accepted; async reset asserted mid-EMIT → px_valid drops immediately and tri_ready=1.
